// File: rtl/kf8237_address_and_count_registers.sv
// Per-channel base/current address and word-count registers with byte pointer and terminal count.
// Latency: CPU writes and transfer updates land on the next edge; read_data/transfer_address are combinational; TC pulses the cycle after the update.
// Backpressure: none; every strobe and transfer_update pulse is consumed in the cycle it is presented.
//
// Ports:
//   clock, reset                        rising-edge clock, synchronous active-high reset
//   internal_data_bus                   latched CPU write byte
//   write_base_and_current_address/_word_count  one-cycle per-channel write strobes
//   clear_byte_pointer, set_byte_pointer, master_clear  byte pointer control
//   read_current_address/_word_count    level per-channel read strobes
//   transfer_channel, transfer_update, address_decrement, autoinitialize  DMA transfer update
//   read_data                           CPU read byte
//   transfer_address                    current address of transfer_channel
//   terminal_count                      one-cycle TC pulse per channel
module kf8237_address_and_count_registers #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               internal_data_bus,
    input  logic [3:0]               write_base_and_current_address,
    input  logic [3:0]               write_base_and_current_word_count,
    input  logic                     clear_byte_pointer,
    input  logic                     set_byte_pointer,
    input  logic                     master_clear,
    input  logic [3:0]               read_current_address,
    input  logic [3:0]               read_current_word_count,
    input  logic [1:0]               transfer_channel,
    input  logic                     transfer_update,
    input  logic                     address_decrement,
    input  logic [3:0]               autoinitialize,
    output logic [7:0]               read_data,
    output logic [ADDRESS_WIDTH-1:0] transfer_address,
    output logic [3:0]               terminal_count
);

    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0]   CNT_ONE  = COUNT_WIDTH'(1);

    logic [ADDRESS_WIDTH-1:0] base_addr_q [4];
    logic [ADDRESS_WIDTH-1:0] base_addr_d [4];
    logic [ADDRESS_WIDTH-1:0] cur_addr_q  [4];
    logic [ADDRESS_WIDTH-1:0] cur_addr_d  [4];
    logic [COUNT_WIDTH-1:0]   base_cnt_q  [4];
    logic [COUNT_WIDTH-1:0]   base_cnt_d  [4];
    logic [COUNT_WIDTH-1:0]   cur_cnt_q   [4];
    logic [COUNT_WIDTH-1:0]   cur_cnt_d   [4];
    logic                     bp_q, bp_d;
    logic                     rd_active_q, rd_active_d;
    logic [3:0]               tc_q, tc_d;

    logic                     any_wr;
    logic                     any_rd;
    logic [15:0]              read_sel;
    logic                     read_hit;

    // Replace one byte of a 16-bit register, chosen by the byte pointer.
    function automatic logic [15:0] merge_byte(input logic [15:0] old, input logic [7:0] dat,
                                               input logic hi);
        return hi ? {dat, old[7:0]} : {old[15:8], dat};
    endfunction

    assign any_wr = (|write_base_and_current_address) | (|write_base_and_current_word_count);
    assign any_rd = (|read_current_address) | (|read_current_word_count);

    always_comb begin : next_state
        // A read toggles the pointer once, on the first idle cycle after the strobe,
        // so a strobe held for many cycles still counts as a single access.
        rd_active_d = any_rd;
        if (master_clear || clear_byte_pointer) begin
            bp_d = 1'b0;
        end else if (set_byte_pointer) begin
            bp_d = 1'b1;
        end else if (any_wr || (rd_active_q && !any_rd)) begin
            bp_d = ~bp_q;
        end else begin
            bp_d = bp_q;
        end

        for (int c = 0; c < 4; c++) begin
            base_addr_d[c] = base_addr_q[c];
            base_cnt_d[c]  = base_cnt_q[c];
            cur_addr_d[c]  = cur_addr_q[c];
            cur_cnt_d[c]   = cur_cnt_q[c];
            tc_d[c]        = 1'b0;

            if (transfer_update && (transfer_channel == 2'(c))) begin
                cur_addr_d[c] = address_decrement ? cur_addr_q[c] - ADDR_ONE
                                                  : cur_addr_q[c] + ADDR_ONE;
                cur_cnt_d[c]  = cur_cnt_q[c] - CNT_ONE;
                // TC fires when the count was already zero before this transfer.
                if (cur_cnt_q[c] == '0) begin
                    tc_d[c] = 1'b1;
                    if (autoinitialize[c]) begin
                        cur_addr_d[c] = base_addr_q[c];
                        cur_cnt_d[c]  = base_cnt_q[c];
                    end
                end
            end

            // A CPU write overrides the transfer result for the register it targets only.
            if (write_base_and_current_address[c]) begin
                base_addr_d[c] = merge_byte(base_addr_q[c], internal_data_bus, bp_q);
                cur_addr_d[c]  = merge_byte(cur_addr_q[c], internal_data_bus, bp_q);
            end
            if (write_base_and_current_word_count[c]) begin
                base_cnt_d[c] = merge_byte(base_cnt_q[c], internal_data_bus, bp_q);
                cur_cnt_d[c]  = merge_byte(cur_cnt_q[c], internal_data_bus, bp_q);
            end
        end

        if (master_clear) begin
            tc_d = 4'b0000;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            base_addr_q <= '{default: '0};
            cur_addr_q  <= '{default: '0};
            base_cnt_q  <= '{default: '0};
            cur_cnt_q   <= '{default: '0};
            bp_q        <= 1'b0;
            rd_active_q <= 1'b0;
            tc_q        <= 4'b0000;
        end else begin
            base_addr_q <= base_addr_d;
            cur_addr_q  <= cur_addr_d;
            base_cnt_q  <= base_cnt_d;
            cur_cnt_q   <= cur_cnt_d;
            bp_q        <= bp_d;
            rd_active_q <= rd_active_d;
            tc_q        <= tc_d;
        end
    end

    // Scan from channel 3 down so the lowest channel's strobe is applied last and wins;
    // within a channel the address is applied after the count so it wins.
    always_comb begin : read_mux
        read_sel  = '0;
        read_hit  = 1'b0;
        read_data = 8'h00;
        for (int c = 3; c >= 0; c--) begin
            if (read_current_word_count[c]) begin
                read_sel = cur_cnt_q[c];
                read_hit = 1'b1;
            end
            if (read_current_address[c]) begin
                read_sel = cur_addr_q[c];
                read_hit = 1'b1;
            end
        end
        if (read_hit) begin
            read_data = bp_q ? read_sel[15:8] : read_sel[7:0];
        end
    end

    assign transfer_address = cur_addr_q[transfer_channel];
    assign terminal_count   = tc_q;

endmodule

// File: tb/tb_kf8237_address_and_count_registers.sv
module tb_kf8237_address_and_count_registers;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  internal_data_bus;
    logic [3:0]  write_base_and_current_address;
    logic [3:0]  write_base_and_current_word_count;
    logic        clear_byte_pointer;
    logic        set_byte_pointer;
    logic        master_clear;
    logic [3:0]  read_current_address;
    logic [3:0]  read_current_word_count;
    logic [1:0]  transfer_channel;
    logic        transfer_update;
    logic        address_decrement;
    logic [3:0]  autoinitialize;
    logic [7:0]  read_data;
    logic [15:0] transfer_address;
    logic [3:0]  terminal_count;

    always #5 clock = ~clock;

    kf8237_address_and_count_registers dut (
        .clock                            (clock),
        .reset                            (reset),
        .internal_data_bus                (internal_data_bus),
        .write_base_and_current_address   (write_base_and_current_address),
        .write_base_and_current_word_count(write_base_and_current_word_count),
        .clear_byte_pointer               (clear_byte_pointer),
        .set_byte_pointer                 (set_byte_pointer),
        .master_clear                     (master_clear),
        .read_current_address             (read_current_address),
        .read_current_word_count          (read_current_word_count),
        .transfer_channel                 (transfer_channel),
        .transfer_update                  (transfer_update),
        .address_decrement                (address_decrement),
        .autoinitialize                   (autoinitialize),
        .read_data                        (read_data),
        .transfer_address                 (transfer_address),
        .terminal_count                   (terminal_count)
    );

    // ctl = {master_clear, set_byte_pointer, clear_byte_pointer}
    // chk = {check tc, check transfer_address, check read_data}
    typedef struct {
        logic        rst;
        logic [3:0]  wa, wc, ra, rc;
        logic [7:0]  d;
        logic        upd;
        logic [1:0]  ch;
        logic        dec;
        logic [3:0]  ai;
        logic [2:0]  ctl;
        logic [2:0]  chk;
        logic [7:0]  erd;
        logic [15:0] eta;
        logic [3:0]  etc_;
        string       name;
    } vec_t;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    // Reference state: plain register arrays updated by arithmetic rules.
    logic [15:0] m_ba[4], m_ca[4], m_bc[4], m_cc[4];
    logic        m_bp, m_rdw;
    logic [3:0]  m_tc;

    function automatic vec_t V(string n, logic [3:0] wa, logic [3:0] wc, logic [3:0] ra,
                               logic [3:0] rc, logic [7:0] d, logic upd, logic [1:0] ch,
                               logic dec, logic [3:0] ai, logic [2:0] ctl, logic [2:0] chk,
                               logic [7:0] erd, logic [15:0] eta, logic [3:0] etc_);
        vec_t v;
        v.rst = 1'b0; v.wa = wa; v.wc = wc; v.ra = ra; v.rc = rc; v.d = d;
        v.upd = upd; v.ch = ch; v.dec = dec; v.ai = ai; v.ctl = ctl; v.chk = chk;
        v.erd = erd; v.eta = eta; v.etc_ = etc_; v.name = n;
        return v;
    endfunction

    function automatic vec_t idle();
        return V("idle", 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 0);
    endfunction

    function automatic logic [15:0] put(logic [15:0] old, logic [7:0] d, logic hi);
        return hi ? {d, old[7:0]} : {old[15:8], d};
    endfunction

    function automatic logic [7:0] pick(logic [15:0] x);
        return m_bp ? x[15:8] : x[7:0];
    endfunction

    function automatic logic [7:0] model_rd(vec_t v);
        for (int c = 0; c < 4; c++) begin
            if (v.ra[c]) return pick(m_ca[c]);
            if (v.rc[c]) return pick(m_cc[c]);
        end
        return 8'h00;
    endfunction

    task automatic model_step(vec_t v);
        logic [15:0] na[4], nc[4];
        logic [3:0]  ntc;
        logic        any_wr, any_rd;
        if (v.rst) begin
            for (int c = 0; c < 4; c++) begin
                m_ba[c] = 0; m_ca[c] = 0; m_bc[c] = 0; m_cc[c] = 0;
            end
            m_bp = 0; m_rdw = 0; m_tc = 0;
            return;
        end
        ntc = 0;
        for (int c = 0; c < 4; c++) begin
            na[c] = m_ca[c];
            nc[c] = m_cc[c];
            if (v.upd && v.ch == 2'(c)) begin
                na[c] = v.dec ? m_ca[c] - 16'd1 : m_ca[c] + 16'd1;
                nc[c] = m_cc[c] - 16'd1;
                if (m_cc[c] == 16'h0000) begin
                    ntc[c] = 1'b1;
                    if (v.ai[c]) begin
                        na[c] = m_ba[c];
                        nc[c] = m_bc[c];
                    end
                end
            end
            if (v.wa[c]) begin
                m_ba[c] = put(m_ba[c], v.d, m_bp);
                na[c]   = put(m_ca[c], v.d, m_bp);
            end
            if (v.wc[c]) begin
                m_bc[c] = put(m_bc[c], v.d, m_bp);
                nc[c]   = put(m_cc[c], v.d, m_bp);
            end
        end
        for (int c = 0; c < 4; c++) begin
            m_ca[c] = na[c];
            m_cc[c] = nc[c];
        end
        any_wr = (v.wa != 0) || (v.wc != 0);
        any_rd = (v.ra != 0) || (v.rc != 0);
        if (v.ctl[2] || v.ctl[0])              m_bp = 1'b0;
        else if (v.ctl[1])                     m_bp = 1'b1;
        else if (any_wr || (m_rdw && !any_rd)) m_bp = ~m_bp;
        m_rdw = any_rd;
        m_tc  = v.ctl[2] ? 4'b0000 : ntc;
    endtask

    task automatic check(string name, int idx, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(vec_t v, int idx);
        @(negedge clock);
        reset                             = v.rst;
        write_base_and_current_address    = v.wa;
        write_base_and_current_word_count = v.wc;
        read_current_address              = v.ra;
        read_current_word_count           = v.rc;
        internal_data_bus                 = v.d;
        transfer_update                   = v.upd;
        transfer_channel                  = v.ch;
        address_decrement                 = v.dec;
        autoinitialize                    = v.ai;
        master_clear                      = v.ctl[2];
        set_byte_pointer                  = v.ctl[1];
        clear_byte_pointer                = v.ctl[0];
        #1;
        if (chk_on) begin
            check("model_rd", idx, 16'(read_data), 16'(model_rd(v)));
            check("model_ta", idx, transfer_address, m_ca[v.ch]);
            check("model_tc", idx, 16'(terminal_count), 16'(m_tc));
        end
        if (v.chk[0]) check({v.name, ".rd"}, idx, 16'(read_data), 16'(v.erd));
        if (v.chk[1]) check({v.name, ".ta"}, idx, transfer_address, v.eta);
        if (v.chk[2]) check({v.name, ".tc"}, idx, 16'(terminal_count), 16'(v.etc_));
        model_step(v);
    endtask

    vec_t tbl[$];

    initial begin
        vec_t v;
        int   hold;
        logic [3:0] hra, hrc;

        // Directed sequences: (name, wa, wc, ra, rc, d, upd, ch, dec, ai, ctl, chk, erd, eta, tc)
        tbl.push_back(V("rst_state", 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 7, 8'h00, 16'h0000, 0));
        tbl.push_back(V("p1_wr_lo",  1, 0, 0, 0, 8'h34, 0, 0, 0, 0, 0, 3, 8'h00, 16'h0000, 0));
        tbl.push_back(V("p1_wr_hi",  1, 0, 0, 0, 8'h12, 0, 0, 0, 0, 0, 2, 8'h00, 16'h0034, 0));
        tbl.push_back(V("p1_rd_lo",  0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 3, 8'h34, 16'h1234, 0));
        tbl.push_back(idle());
        tbl.push_back(V("p1_rd_hi",  0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 1, 8'h12, 16'h0000, 0));
        tbl.push_back(idle());
        tbl.push_back(V("p2_wa_lo",  4, 0, 0, 0, 8'hFF, 0, 2, 0, 0, 0, 0, 8'h00, 16'h0000, 0));
        tbl.push_back(V("p2_wa_hi",  4, 0, 0, 0, 8'hFF, 0, 2, 0, 0, 0, 0, 8'h00, 16'h0000, 0));
        tbl.push_back(V("p2_wc_lo",  0, 4, 0, 0, 8'h02, 0, 2, 0, 0, 0, 0, 8'h00, 16'h0000, 0));
        tbl.push_back(V("p2_wc_hi",  0, 4, 0, 0, 8'h00, 0, 2, 0, 0, 0, 0, 8'h00, 16'h0000, 0));
        tbl.push_back(V("p2_upd1",   0, 0, 0, 0, 8'h00, 1, 2, 0, 0, 0, 6, 8'h00, 16'hFFFF, 0));
        tbl.push_back(V("p2_upd2",   0, 0, 0, 0, 8'h00, 1, 2, 0, 0, 0, 6, 8'h00, 16'h0000, 0));
        tbl.push_back(V("p2_upd3",   0, 0, 0, 0, 8'h00, 1, 2, 0, 0, 0, 6, 8'h00, 16'h0001, 0));
        tbl.push_back(V("p2_tc",     0, 0, 0, 0, 8'h00, 0, 2, 0, 0, 0, 6, 8'h00, 16'h0002, 4'b0100));
        tbl.push_back(V("p2_cnt_lo", 0, 0, 0, 4, 8'h00, 0, 2, 0, 0, 0, 5, 8'hFF, 16'h0000, 0));
        tbl.push_back(idle());
        tbl.push_back(V("p2_cnt_hi", 0, 0, 0, 4, 8'h00, 0, 2, 0, 0, 0, 1, 8'hFF, 16'h0000, 0));
        tbl.push_back(idle());
        tbl.push_back(V("p3_wa_lo",  2, 0, 0, 0, 8'h00, 0, 1, 1, 2, 0, 0, 8'h00, 16'h0000, 0));
        tbl.push_back(V("p3_wa_hi",  2, 0, 0, 0, 8'h10, 0, 1, 1, 2, 0, 0, 8'h00, 16'h0000, 0));
        tbl.push_back(V("p3_upd",    0, 0, 0, 0, 8'h00, 1, 1, 1, 2, 0, 6, 8'h00, 16'h1000, 0));
        tbl.push_back(V("p3_tc",     0, 0, 0, 0, 8'h00, 0, 1, 1, 2, 0, 6, 8'h00, 16'h1000, 4'b0010));
        tbl.push_back(V("p3_tc_end", 0, 0, 0, 2, 8'h00, 0, 1, 1, 2, 0, 5, 8'h00, 16'h0000, 0));
        tbl.push_back(idle());
        tbl.push_back(V("p3_cnt_hi", 0, 0, 0, 2, 8'h00, 0, 1, 1, 2, 0, 1, 8'h00, 16'h0000, 0));
        tbl.push_back(idle());
        tbl.push_back(V("p4_wc_lo",  0, 8, 0, 0, 8'hCD, 0, 3, 0, 0, 0, 0, 8'h00, 16'h0000, 0));
        tbl.push_back(V("p4_wc_hi",  0, 8, 0, 0, 8'hAB, 0, 3, 0, 0, 0, 0, 8'h00, 16'h0000, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(V("p4_hold", 0, 0, 0, 8, 8'h00, 0, 3, 0, 0, 0, 1, 8'hCD, 16'h0000, 0));
        tbl.push_back(V("p4_drop",   0, 0, 0, 0, 8'h00, 0, 3, 0, 0, 0, 1, 8'h00, 16'h0000, 0));
        tbl.push_back(V("p4_rd_hi",  0, 0, 0, 8, 8'h00, 0, 3, 0, 0, 0, 1, 8'hAB, 16'h0000, 0));
        tbl.push_back(idle());
        tbl.push_back(V("p5_wr_upd", 1, 0, 0, 0, 8'h77, 1, 0, 0, 0, 0, 6, 8'h00, 16'h1234, 0));
        tbl.push_back(V("p5_after",  0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 6, 8'h00, 16'h1277, 4'b0001));
        tbl.push_back(V("p5_cnt_hi", 0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 0, 1, 8'hFF, 16'h0000, 0));
        tbl.push_back(idle());
        tbl.push_back(V("p5_adr_lo", 0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 1, 8'h77, 16'h0000, 0));
        tbl.push_back(idle());
        tbl.push_back(V("p5_adr_hi", 0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 1, 8'h12, 16'h0000, 0));
        tbl.push_back(idle());
        tbl.push_back(V("p6_wr",     2, 0, 0, 0, 8'h55, 0, 1, 0, 0, 0, 0, 8'h00, 16'h0000, 0));
        tbl.push_back(V("p6_clr",    0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 3'b001, 0, 8'h00, 16'h0000, 0));
        tbl.push_back(V("p6_wr2",    2, 0, 0, 0, 8'h66, 0, 1, 0, 0, 0, 0, 8'h00, 16'h0000, 0));
        tbl.push_back(V("p6_rd_hi",  0, 0, 2, 0, 8'h00, 0, 1, 0, 0, 0, 3, 8'h10, 16'h1066, 0));
        tbl.push_back(idle());
        tbl.push_back(V("p6_set",    0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 3'b010, 0, 8'h00, 16'h0000, 0));
        tbl.push_back(V("p6_rd_set", 0, 0, 2, 0, 8'h00, 0, 0, 0, 0, 0, 1, 8'h10, 16'h0000, 0));
        tbl.push_back(idle());
        tbl.push_back(V("p6_set2",   0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 3'b010, 0, 8'h00, 16'h0000, 0));
        tbl.push_back(V("p6_mc",     0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 3'b100, 2, 8'h00, 16'h1277, 0));
        tbl.push_back(V("p6_rd_mc",  0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 3, 8'h77, 16'h1277, 0));
        tbl.push_back(idle());
        tbl.push_back(V("p6_rd_ch1", 0, 0, 2, 0, 8'h00, 0, 1, 0, 0, 0, 3, 8'h10, 16'h1066, 0));
        tbl.push_back(idle());
        tbl.push_back(V("multi_same", 0, 0, 2, 2, 8'h00, 0, 1, 0, 0, 0, 1, 8'h66, 16'h0000, 0));
        tbl.push_back(idle());
        tbl.push_back(V("multi_low", 0, 0, 4'hA, 0, 8'h00, 0, 1, 0, 0, 0, 1, 8'h10, 16'h0000, 0));
        tbl.push_back(idle());
        tbl.push_back(V("mc_tc",     0, 0, 0, 0, 8'h00, 1, 1, 0, 0, 3'b100, 2, 8'h00, 16'h1066, 0));
        tbl.push_back(V("mc_tc_chk", 0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 6, 8'h00, 16'h1067, 0));

        // Reset for two cycles, unchecked because outputs are unknown before reset.
        v = idle();
        v.rst = 1'b1;
        apply(v, -2);
        apply(v, -1);
        chk_on = 1'b1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Randomized traffic against the reference model.
        hold = 0;
        hra  = 0;
        hrc  = 0;
        for (int i = 0; i < 3000; i++) begin
            v = idle();
            v.name = "rand";
            v.rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 9) == 0) v.wa = 4'b0001 << $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) v.wc = 4'b0001 << $urandom_range(0, 3);
            if (hold > 0) begin
                hold--;
            end else if ($urandom_range(0, 3) == 0) begin
                hra = 0;
                hrc = 0;
                if ($urandom_range(0, 1) == 1) hra = 4'b0001 << $urandom_range(0, 3);
                else                            hrc = 4'b0001 << $urandom_range(0, 3);
                hold = $urandom_range(0, 4);
            end else begin
                hra = 0;
                hrc = 0;
            end
            v.ra = hra;
            v.rc = hrc;
            case ($urandom_range(0, 3))
                0:       v.d = 8'h00;
                1:       v.d = 8'h01;
                2:       v.d = 8'hFF;
                default: v.d = 8'($urandom);
            endcase
            v.upd = ($urandom_range(0, 2) == 0);
            v.ch  = 2'($urandom_range(0, 3));
            v.dec = 1'($urandom);
            v.ai  = 4'($urandom);
            v.ctl = {($urandom_range(0, 49) == 0), ($urandom_range(0, 29) == 0),
                     ($urandom_range(0, 29) == 0)};
            apply(v, 1000 + i);
        end

        apply(idle(), 9999);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kf8237_address_and_count_registers.md
Name: kf8237_address_and_count_registers

Overview:
Per-channel base/current address and word-count register file for the KF8237 DMA controller, directly downstream of the bus control logic. Consumes the decoded write/read strobes and the latched internal data bus, and maintains the byte-pointer flip-flop. Serves 8-bit CPU reads of current address and count. Updates the current registers on each DMA transfer and signals terminal count per channel.

Parameters:
ADDRESS_WIDTH, 16, width of base/current address registers (fixed 16 for 8237 compatibility)
COUNT_WIDTH, 16, width of base/current word-count registers (fixed 16)

Ports:
clock  in  1  system clock, rising-edge
reset  in  1  synchronous, active-high reset
internal_data_bus  in  8  latched CPU write data
write_base_and_current_address  in  4  one-cycle write strobe per channel
write_base_and_current_word_count  in  4  one-cycle write strobe per channel
clear_byte_pointer  in  1  one-cycle clear of byte pointer
set_byte_pointer  in  1  level; forces byte pointer to 1
master_clear  in  1  one-cycle software master clear
read_current_address  in  4  level read strobe per channel, held for the CPU read
read_current_word_count  in  4  level read strobe per channel
transfer_channel  in  2  channel being serviced
transfer_update  in  1  one-cycle pulse: one transfer completed on transfer_channel
address_decrement  in  1  mode bit for transfer_channel: 1 = decrement address, 0 = increment
autoinitialize  in  4  per-channel autoinit enable from mode registers
read_data  out  8  CPU read data
transfer_address  out  16  current address of transfer_channel
terminal_count  out  4  one-cycle TC pulse per channel

Behaviour:
- Reset: all base/current registers 0x0000, byte pointer 0, terminal_count 0. read_data and transfer_address reflect zeroed registers.
- Byte pointer (bp):
  - Priority: reset > master_clear = clear_byte_pointer (clear to 0) > set_byte_pointer (to 1) > toggle.
  - Toggle on the cycle after any write strobe bit is high.
  - Toggle on the first cycle a read strobe (any bit of either read vector) is low after being high. Exactly one toggle per CPU access, whatever the strobe length.
- Write: a strobe for channel c writes internal_data_bus into both base and current of that register. bp=0 writes bits [7:0]; bp=1 writes bits [15:8]. The other byte is unchanged. Registered; visible the next cycle.
- Read (combinational):
  - read_data = selected current register byte: low if bp=0, high if bp=1.
  - Strobes are expected one-hot. If more than one is set, the lowest channel wins, and address wins over count.
  - No strobe gives 0x00.
- transfer_address is combinational: the current address of transfer_channel before any update on this edge.
- Transfer update (transfer_update=1, channel c), applied at the clock edge:
  - Current address = address ±1, per address_decrement, mod 2^16 (0xFFFF+1 gives 0x0000; 0x0000-1 gives 0xFFFF).
  - Current count = count-1 mod 2^16.
  - If the count was 0x0000 before the update: terminal_count[c]=1 for exactly the next cycle. If autoinitialize[c]=1, current address and count reload from base instead of taking the new values.
  - Base registers are never modified by transfers.
- Simultaneous CPU write and update on the same channel: the CPU write wins for the register being written, and the update is discarded for that register only. The other register still updates, and TC is still evaluated from the pre-update count.
- master_clear: clears bp and terminal_count. Address/count registers keep their values.
- terminal_count is otherwise 0. Pulses for different channels are independent.

Test Plan:
1. Reset, then write ch0 address 0x34 then 0x12 (bp 0→1→0) → read ch0 address returns 0x34 then 0x12; base = current = 0x1234.
2. Write ch2 count 0x0002, then three transfer_update pulses on ch2, increment, address 0xFFFF → address goes 0x0000, 0x0001, 0x0002; count goes 0x0001, 0x0000, 0xFFFF; terminal_count[2] pulses only after the third update.
3. ch1: autoinitialize[1]=1, base address 0x1000, count 0x0000, decrement; one update → terminal_count[1]=1 for one cycle; current address reloads 0x1000 and count 0x0000.
4. Read ch3 count with the strobe held 5 cycles → read_data stable with bp=0 for all 5 cycles; bp=1 only after the strobe drops; the next read returns the high byte.
5. Write strobe for ch0 address with transfer_update on ch0 in the same cycle → the address holds the written byte; count still decrements.
6. clear_byte_pointer after a single-byte write → next write targets the low byte. set_byte_pointer → next read returns the high byte. master_clear leaves all register values intact.
